// File: rtl/atm_pkg.sv
// Shared types for the cash dispenser: denomination codes, note values,
// response codes and FSM state encoding.
package atm_pkg;

    localparam int PLAN_W = 6;

    typedef enum logic [1:0] {
        DENOM_10  = 2'd0,
        DENOM_50  = 2'd1,
        DENOM_100 = 2'd2,
        DENOM_200 = 2'd3
    } denom_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAN,
        ST_DISPENSE,
        ST_RESP
    } state_t;

    localparam logic [1:0] RSP_OK        = 2'd0;
    localparam logic [1:0] RSP_CANT_MAKE = 2'd1;
    localparam logic [1:0] RSP_TOO_MANY  = 2'd2;

    function automatic logic [15:0] denom_value(input denom_t d);
        case (d)
            DENOM_10:  return 16'd10;
            DENOM_50:  return 16'd50;
            DENOM_100: return 16'd100;
            default:   return 16'd200;
        endcase
    endfunction

    // Highest denomination that still has notes planned; DENOM_10 if none.
    function automatic denom_t top_denom(input logic [3:0][PLAN_W-1:0] p);
        denom_t d;
        d = DENOM_10;
        for (int i = 0; i < 4; i++) begin
            if (p[i] != '0) d = denom_t'(2'(i));
        end
        return d;
    endfunction

endpackage

// File: rtl/cash_dispenser_if.sv
// Request / note-feeder / response handshake bundle of the cash dispenser.
interface cash_dispenser_if;
    logic        req_valid;
    logic [15:0] req_amount;
    logic        req_ready;
    logic        note_valid;
    logic [1:0]  note_denom;
    logic        note_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_code;

    modport master (
        output req_valid, req_amount, note_ready,
        input  req_ready, note_valid, note_denom, rsp_valid, rsp_code
    );

    modport slave (
        input  req_valid, req_amount, note_ready,
        output req_ready, note_valid, note_denom, rsp_valid, rsp_code
    );
endinterface

// File: rtl/cash_dispenser_note_planner.sv
// Combinational greedy pick: largest denomination that fits the remaining
// amount and still has stock beyond what is already planned.
module note_planner
    import atm_pkg::*;
#(
    parameter int STOCK_W = 10
) (
    input  logic [15:0]              rem,
    input  logic [3:0][PLAN_W-1:0]   plan,
    input  logic [3:0][STOCK_W-1:0]  stock,
    output logic                     found,
    output denom_t                   denom
);

    always_comb begin
        found = 1'b0;
        denom = DENOM_10;
        for (int i = 3; i >= 0; i--) begin
            if (!found && rem >= denom_value(denom_t'(2'(i))) &&
                32'(plan[i]) < 32'(stock[i])) begin
                found = 1'b1;
                denom = denom_t'(2'(i));
            end
        end
    end

endmodule

// File: rtl/cash_dispenser.sv
// Cash dispenser: plans a greedy note breakdown, then feeds notes one by one.
// Optional cassette refill port enabled by defining CASH_REFILL_EN.
//
// state       | meaning
// ST_IDLE     | ready for a withdrawal request (and refills)
// ST_PLAN     | one greedy planning step per cycle
// ST_DISPENSE | offering planned notes, highest denomination first
// ST_RESP     | one-cycle completion pulse with response code
module cash_dispenser
    import atm_pkg::*;
#(
    parameter int STOCK_W        = 10,
    parameter int STOCK_INIT_10  = 20,
    parameter int STOCK_INIT_50  = 10,
    parameter int STOCK_INIT_100 = 10,
    parameter int STOCK_INIT_200 = 10,
    parameter int MAX_NOTES      = 40
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CASH_REFILL_EN
    input  logic                refill_valid,
    input  logic [1:0]          refill_denom,
    input  logic [STOCK_W-1:0]  refill_count,
`endif
    cash_dispenser_if.slave     bus,
    output logic [STOCK_W-1:0]  stock_10,
    output logic [STOCK_W-1:0]  stock_50,
    output logic [STOCK_W-1:0]  stock_100,
    output logic [STOCK_W-1:0]  stock_200
);

    state_t                     state;
    logic [15:0]                rem;
    logic [3:0][PLAN_W-1:0]     plan;
    logic [3:0][PLAN_W-1:0]     plan_after;
    logic [3:0][STOCK_W-1:0]    stock;
    logic [PLAN_W-1:0]          plan_total;
    logic                       req_ready_q;
    logic                       note_valid_q;
    logic [1:0]                 note_denom_q;
    logic                       rsp_valid_q;
    logic [1:0]                 rsp_code_q;
    logic                       pick_found;
    denom_t                     pick_denom;

    logic                       refill_go;
    logic [1:0]                 refill_den;
    logic [STOCK_W-1:0]         refill_cnt;
    logic [STOCK_W:0]           refill_sum;
    logic [STOCK_W-1:0]         refill_sat;

`ifdef CASH_REFILL_EN
    assign refill_go  = refill_valid;
    assign refill_den = refill_denom;
    assign refill_cnt = refill_count;
`else
    assign refill_go  = 1'b0;
    assign refill_den = 2'd0;
    assign refill_cnt = '0;
`endif

    assign refill_sum = {1'b0, stock[refill_den]} + {1'b0, refill_cnt};
    assign refill_sat = refill_sum[STOCK_W] ? '1 : refill_sum[STOCK_W-1:0];

    assign plan_total = plan[0] + plan[1] + plan[2] + plan[3];

    // Plan as it will look after the currently offered note is taken.
    always_comb begin
        plan_after = plan;
        plan_after[note_denom_q] = plan[note_denom_q] - PLAN_W'(1);
    end

    note_planner #(.STOCK_W(STOCK_W)) u_planner (
        .rem   (rem),
        .plan  (plan),
        .stock (stock),
        .found (pick_found),
        .denom (pick_denom)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            rem          <= '0;
            plan         <= '0;
            stock[0]     <= STOCK_W'(STOCK_INIT_10);
            stock[1]     <= STOCK_W'(STOCK_INIT_50);
            stock[2]     <= STOCK_W'(STOCK_INIT_100);
            stock[3]     <= STOCK_W'(STOCK_INIT_200);
            req_ready_q  <= 1'b1;
            note_valid_q <= 1'b0;
            note_denom_q <= 2'd0;
            rsp_valid_q  <= 1'b0;
            rsp_code_q   <= RSP_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        rem         <= bus.req_amount;
                        plan        <= '0;
                        req_ready_q <= 1'b0;
                        state       <= ST_PLAN;
                    end
                    if (refill_go) stock[refill_den] <= refill_sat;
                end
                ST_PLAN: begin
                    if (pick_found && int'(plan_total) < MAX_NOTES) begin
                        rem              <= rem - denom_value(pick_denom);
                        plan[pick_denom] <= plan[pick_denom] + PLAN_W'(1);
                    end else if (rem == '0 && plan_total == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_code_q  <= RSP_OK;
                        state       <= ST_RESP;
                    end else if (rem == '0) begin
                        note_valid_q <= 1'b1;
                        note_denom_q <= top_denom(plan);
                        state        <= ST_DISPENSE;
                    end else if (int'(plan_total) == MAX_NOTES) begin
                        rsp_valid_q <= 1'b1;
                        rsp_code_q  <= RSP_TOO_MANY;
                        state       <= ST_RESP;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_code_q  <= RSP_CANT_MAKE;
                        state       <= ST_RESP;
                    end
                end
                ST_DISPENSE: begin
                    if (bus.note_ready) begin
                        plan[note_denom_q]  <= plan_after[note_denom_q];
                        stock[note_denom_q] <= stock[note_denom_q] - STOCK_W'(1);
                        if (plan_after != '0) begin
                            note_denom_q <= top_denom(plan_after);
                        end else begin
                            note_valid_q <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            rsp_code_q   <= RSP_OK;
                            state        <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.note_valid = note_valid_q;
    assign bus.note_denom = note_denom_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_code   = rsp_code_q;

    assign stock_10  = stock[0];
    assign stock_50  = stock[1];
    assign stock_100 = stock[2];
    assign stock_200 = stock[3];

endmodule

// File: tb/tb_cash_dispenser.sv
// Self-checking bench for cash_dispenser: directed table, stall/reset
// sequences, and randomized requests against a greedy arithmetic model.
module tb_cash_dispenser;
    import atm_pkg::*;

    localparam int STOCK_W   = 10;
    localparam int MAX_NOTES = 40;
    localparam int INIT_STOCK [4] = '{20, 10, 10, 10};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cash_dispenser_if bus ();
    logic [STOCK_W-1:0] stock_10, stock_50, stock_100, stock_200;

    cash_dispenser #(
        .STOCK_W        (STOCK_W),
        .STOCK_INIT_10  (20),
        .STOCK_INIT_50  (10),
        .STOCK_INIT_100 (10),
        .STOCK_INIT_200 (10),
        .MAX_NOTES      (MAX_NOTES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stock_10  (stock_10),
        .stock_50  (stock_50),
        .stock_100 (stock_100),
        .stock_200 (stock_200)
    );

    int tests = 0;
    int fails = 0;

    int m_stock [4];
    int m_cnt [4];
    int m_code;
    int m_k;
    int last_code;
    int last_notes;

    typedef struct {
        int amount;
        int code;
        int notes;
        int s [4];
    } vec_t;
    vec_t tbl [6];

    function automatic int dval(input int d);
        case (d)
            0:       return 10;
            1:       return 50;
            2:       return 100;
            default: return 200;
        endcase
    endfunction

    function automatic int dut_stock(input int d);
        case (d)
            0:       return int'(stock_10);
            1:       return int'(stock_50);
            2:       return int'(stock_100);
            default: return int'(stock_200);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Greedy breakdown: as many of each denomination as amount, stock and
    // the note limit allow, largest first.
    task automatic model_plan(input int amt);
        int rem;
        int n;
        rem = amt;
        m_k = 0;
        for (int d = 3; d >= 0; d--) begin
            n = rem / dval(d);
            if (n > m_stock[d]) n = m_stock[d];
            if (n > MAX_NOTES - m_k) n = MAX_NOTES - m_k;
            m_cnt[d] = n;
            rem -= n * dval(d);
            m_k += n;
        end
        if (rem == 0)            m_code = 0;
        else if (m_k == MAX_NOTES) m_code = 2;
        else                     m_code = 1;
    endtask

    task automatic check_stock(input string tag);
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s_stock%0d", tag, dval(d)), dut_stock(d), m_stock[d]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"},  int'(bus.req_ready), 1);
        chk({tag, "_note_valid"}, int'(bus.note_valid), 0);
        chk({tag, "_note_denom"}, int'(bus.note_denom), 0);
        chk({tag, "_rsp_valid"},  int'(bus.rsp_valid), 0);
        chk({tag, "_rsp_code"},   int'(bus.rsp_code), 0);
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s_stock%0d", tag, dval(d)), dut_stock(d), INIT_STOCK[d]);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req_valid  = 1'b0;
        bus.note_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        m_stock = INIT_STOCK;
    endtask

    // mode 0: feeder always ready, 1: random stalls, 2: first note stalled 5 cycles
    task automatic run_req(input int amt, input int mode);
        int exp_q [$];
        int c, w, first_c, last_hs, rsp_c, idx, stall_left, viol, bad_den;
        logic prev_stall;
        logic [1:0] prev_den;
        logic r;
        model_plan(amt);
        if (m_code == 0)
            for (int d = 3; d >= 0; d--)
                for (int j = 0; j < m_cnt[d]; j++) exp_q.push_back(d);
        @(negedge clk);
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_idle", int'(bus.req_ready), 1);
        bus.req_valid  = 1'b1;
        bus.req_amount = 16'(amt);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        c = 0; first_c = -1; last_hs = -1; rsp_c = -1; idx = 0;
        viol = 0; bad_den = 0; prev_stall = 1'b0; prev_den = 2'd0;
        stall_left = (mode == 2) ? 5 : 0;
        last_code = -1; last_notes = 0;
        bus.note_ready = 1'b0;
        while (rsp_c < 0 && c < 300) begin
            @(negedge clk);
            c++;
            if (c == 1) chk("req_ready_busy", int'(bus.req_ready), 0);
            if (prev_stall && (bus.note_valid !== 1'b1 || bus.note_denom !== prev_den)) viol++;
            prev_stall = 1'b0;
            if (bus.note_valid === 1'b1) begin
                if (first_c < 0) first_c = c;
                if (idx >= exp_q.size() || int'(bus.note_denom) != exp_q[idx]) bad_den++;
                case (mode)
                    0: r = 1'b1;
                    1: r = ($urandom_range(0, 3) != 0);
                    default: begin
                        if (stall_left > 0) begin
                            r = 1'b0;
                            stall_left--;
                        end else r = 1'b1;
                    end
                endcase
                bus.note_ready = r;
                if (r) begin
                    idx++;
                    last_hs = c;
                    last_notes++;
                end else begin
                    prev_stall = 1'b1;
                    prev_den   = bus.note_denom;
                end
            end else begin
                bus.note_ready = 1'b0;
            end
            if (bus.rsp_valid === 1'b1) begin
                rsp_c = c;
                last_code = int'(bus.rsp_code);
            end
        end
        bus.note_ready = 1'b0;
        chk("rsp_seen", int'(rsp_c >= 0), 1);
        chk("rsp_code", last_code, m_code);
        chk("note_count", last_notes, (m_code == 0) ? m_k : 0);
        chk("note_order", bad_den, 0);
        chk("note_stable", viol, 0);
        if (m_code == 0 && m_k > 0) begin
            chk("first_note_cycle", first_c, m_k + 2);
            chk("rsp_cycle", rsp_c, last_hs + 1);
        end else begin
            chk("rsp_cycle", rsp_c, m_k + 2);
            chk("no_note", first_c, -1);
        end
        if (m_code == 0)
            for (int d = 0; d < 4; d++) m_stock[d] -= m_cnt[d];
        @(negedge clk);
        chk("rsp_pulse", int'(bus.rsp_valid), 0);
        chk("back_idle", int'(bus.req_ready), 1);
        check_stock("req");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        tbl[0] = '{amount: 380,  code: 0, notes: 6, s: '{17, 9, 9, 9}};
        tbl[1] = '{amount: 15,   code: 1, notes: 0, s: '{17, 9, 9, 9}};
        tbl[2] = '{amount: 5000, code: 2, notes: 0, s: '{17, 9, 9, 9}};
        tbl[3] = '{amount: 0,    code: 0, notes: 0, s: '{17, 9, 9, 9}};
        tbl[4] = '{amount: 60,   code: 0, notes: 2, s: '{16, 8, 9, 9}};
        tbl[5] = '{amount: 20,   code: 0, notes: 2, s: '{14, 8, 9, 9}};

        rst = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_amount = 16'd0;
        bus.note_ready = 1'b0;
        #12;
        chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;
        m_stock = INIT_STOCK;

        for (int i = 0; i < 6; i++) begin
            run_req(tbl[i].amount, 0);
            chk($sformatf("tbl%0d_code", i), last_code, tbl[i].code);
            chk($sformatf("tbl%0d_notes", i), last_notes, tbl[i].notes);
            for (int d = 0; d < 4; d++)
                chk($sformatf("tbl%0d_stock%0d", i, dval(d)), dut_stock(d), tbl[i].s[d]);
        end

        // 250 with the first note held off by the feeder
        run_req(250, 2);
        chk("stall_code", last_code, 0);
        chk("stall_notes", last_notes, 2);
        chk("stall_stock200", int'(stock_200), 8);
        chk("stall_stock50", int'(stock_50), 7);

        // reset in the middle of a 3-note dispense
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_amount = 16'd350;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (bus.note_valid !== 1'b1 && w < 20);
        chk("mid_first_denom", int'(bus.note_denom), 3);
        bus.note_ready = 1'b1;
        @(negedge clk);
        chk("mid_second_valid", int'(bus.note_valid), 1);
        chk("mid_second_denom", int'(bus.note_denom), 2);
        chk("mid_stock200", int'(stock_200), 7);
        bus.note_ready = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b1;
        m_stock = INIT_STOCK;
        run_req(100, 0);
        chk("post_rst_code", last_code, 0);
        chk("post_rst_notes", last_notes, 1);

        for (int i = 0; i < 40; i++) begin
            int amt;
            if (i == 20) do_reset();
            if ($urandom_range(0, 7) == 0) amt = $urandom_range(0, 2000);
            else                          amt = $urandom_range(0, 50) * 10;
            run_req(amt, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cash_dispenser.md
# cash_dispenser

Cash-dispensing back end for the ATM controller. It accepts an approved withdrawal amount, plans a note breakdown against the cassette inventory, and issues notes one at a time to the mechanical feeder over a valid/ready handshake. It then reports success or a reject code. It sits between the ATM control FSM, which requests the withdrawal, and the note-feeder mechanism. It owns the per-denomination cassette stock counters.

## Interface
Parameters:
- STOCK_W, 10: width of each cassette stock counter.
- STOCK_INIT_10 / _50 / _100 / _200, 20 / 10 / 10 / 10: reset stock per denomination.
- MAX_NOTES, 40: maximum notes in one withdrawal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  withdrawal request.
- req_amount  in  16  amount, in currency units.
- req_ready  out  1  high only in IDLE.
- note_valid  out  1  a note is offered to the feeder.
- note_denom  out  2  denomination code: 0=10, 1=50, 2=100, 3=200.
- note_ready  in  1  feeder accepts the note.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_code  out  2  0=OK, 1=CANT_MAKE, 2=TOO_MANY, 3=reserved.
- stock_10 / stock_50 / stock_100 / stock_200  out  STOCK_W each  current inventory.

## Operation
- States:
  - IDLE: req_ready=1. A transfer (req_valid & req_ready) latches `rem` = req_amount, clears the plan counters, and moves to PLAN.
  - PLAN: one step per cycle. Pick the largest denomination d with rem ≥ value(d) and plan[d] < stock[d].
    - If such a d exists and the total planned < MAX_NOTES: rem -= value(d), plan[d]++.
    - Else if rem==0 and the plan is empty: go to RESP with OK.
    - Else if rem==0: go to DISPENSE.
    - Else if the total planned == MAX_NOTES: go to RESP with TOO_MANY.
    - Otherwise: go to RESP with CANT_MAKE.
  - DISPENSE:
    - note_valid=1 and note_denom = the highest code with plan≠0. Notes go out in descending order.
    - On note_valid & note_ready: plan[d]--, stock[d]--.
    - After the last handshake, go to RESP with OK.
  - RESP: rsp_valid=1 with rsp_code for one cycle, then IDLE.
- The block never dispenses partially. A reject leaves stock untouched.
- Selection is greedy. A combination that exists only via a non-greedy choice is rejected as CANT_MAKE; this is the defined behaviour.
- Arithmetic is 16-bit unsigned on rem. Subtraction happens only when rem ≥ value, so it never underflows.
- The note-count sum is 6 bits wide and compared against MAX_NOTES.
- Stock counters never go below 0. Planning bounds them by construction.

## Timing
- Reset values:
  - State = IDLE.
  - req_ready=1, note_valid=0, note_denom=0, rsp_valid=0, rsp_code=0.
  - plan counters = 0, rem = 0.
  - stock_* = STOCK_INIT_*.
- Latency for a request of k notes:
  - Request accepted at edge N.
  - PLAN occupies cycles N+1 .. N+k+1.
  - note_valid rises in cycle N+k+2.
  - With note_ready held high, one note per cycle.
  - rsp_valid is asserted the cycle after the last handshake.
- Amount 0 completes with OK in the second cycle after acceptance. No note_valid is issued.
- note_valid and note_denom stay stable while note_ready=0. note_valid does not drop until the handshake completes.
- req_valid outside IDLE is ignored. The requester holds it until req_ready.
- Reset mid-operation aborts immediately. The plan is discarded and stock reloads STOCK_INIT_*; notes already handed over are not restored.

## Configuration
- CASH_REFILL_EN:
  - Defined: adds the inputs refill_valid (1), refill_denom (2) and refill_count (STOCK_W).
  - A refill is applied only in IDLE: stock[refill_denom] += refill_count, saturating at 2^STOCK_W−1.
  - refill_valid outside IDLE is ignored.
  - Undefined: these ports do not exist, and stock changes only by dispensing or reset.

## Structure
- Shared package `atm_pkg` holds:
  - the denomination code typedef;
  - the value lookup (10/50/100/200);
  - the rsp_code constants;
  - the state encoding.
- One sub-module, `note_planner`: combinational largest-feasible-denomination selection from rem, plan and stock. The FSM, stock counters and handshake stay in cash_dispenser.

## Test plan
- Default stock, request 380 → notes 200, 100, 50, 10, 10, 10 in order; rsp OK; stock becomes 9/9/9/17 (200/100/50/10).
- Request 15 → rsp_code=1 (CANT_MAKE); no note_valid; stock unchanged.
- Request 5000 → rsp_code=2 (TOO_MANY) after 40 planned notes; no notes issued; stock unchanged.
- Request 250 with note_ready low for 5 cycles on the first note → note_valid and note_denom=3 stable throughout; then 200 and 50 are delivered; rsp OK.
- Request 0 → rsp OK with no note_valid; back in IDLE with req_ready=1.
- Reset asserted in DISPENSE after 1 of 3 notes → all outputs return to reset values asynchronously and stock returns to STOCK_INIT_*; a new request of 100 then dispenses normally.
